dmem_arbiter: RTL and testbench

- Two-master arbiter that shares the single data-memory port between requester A (core load/store unit) and requester B (debug/DMA master).
- Sequences each access through the memory's stall protocol: one-cycle command issue, then wait for stall release.
- Returns read data plus a one-cycle acknowledge to the winning requester.
- Grants round-robin, with a watchdog that aborts a hung access.

---
 rtl/dmem_arbiter.sv | 157 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// ============================================================================
// Module  : dmem_arbiter
// Brief   : Round-robin arbiter sharing one stalling data-memory port between
//           requester A (load/store unit) and requester B (debug/DMA). Each
//           access is sequenced IDLE -> ISSUE -> WAIT -> DONE, with a watchdog
//           that aborts a WAIT that never sees the stall released.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module dmem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 16,   // legal range 4..255
  parameter bit          A_FIRST        = 1'b1  // first contended winner: 1 = A, 0 = B
) (
  input  logic        clk,
  input  logic        rst_n,
  // requester A
  input  logic        a_req,
  input  logic        a_we,
  input  logic [31:0] a_addr,
  input  logic [31:0] a_wdata,
  input  logic [3:0]  a_sign_mask,
  output logic        a_ack,
  output logic [31:0] a_rdata,
  output logic        a_err,
  // requester B
  input  logic        b_req,
  input  logic        b_we,
  input  logic [31:0] b_addr,
  input  logic [31:0] b_wdata,
  input  logic [3:0]  b_sign_mask,
  output logic        b_ack,
  output logic [31:0] b_rdata,
  output logic        b_err,
  // data memory port
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic        mem_memwrite,
  output logic        mem_memread,
  output logic [3:0]  mem_sign_mask,
  input  logic [31:0] mem_read_data,
  input  logic        mem_clk_stall,
  // status
  output logic        busy
);

  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      state_q;
  logic        last_b_q;   // 1 when B won the most recent contended arbitration
  logic        sel_b_q;    // owner of the access in flight
  logic        we_q;       // latched direction of the access in flight
  logic [7:0]  cnt_q;      // watchdog: WAIT cycles spent so far

  logic        win_b;
  logic [7:0]  cnt_inc;
  logic [31:0] rdata_cap;

  // Arbitration winner, watchdog increment and the read data returned at completion
  always_comb begin
    win_b     = b_req & (~a_req | ~last_b_q);
    cnt_inc   = cnt_q + 8'd1;
    rdata_cap = (mem_clk_stall || we_q) ? 32'd0 : mem_read_data;
  end

  // Access sequencer: all outputs are registered and change only on state transitions
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      last_b_q       <= A_FIRST;
      sel_b_q        <= 1'b0;
      we_q           <= 1'b0;
      cnt_q          <= 8'd0;
      a_ack          <= 1'b0;
      a_rdata        <= 32'd0;
      a_err          <= 1'b0;
      b_ack          <= 1'b0;
      b_rdata        <= 32'd0;
      b_err          <= 1'b0;
      mem_addr       <= 32'd0;
      mem_write_data <= 32'd0;
      mem_memwrite   <= 1'b0;
      mem_memread    <= 1'b0;
      mem_sign_mask  <= 4'd0;
      busy           <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // Never issue into a busy memory: a reset or timeout may have left it mid-access
          if (!mem_clk_stall && (a_req || b_req)) begin
            sel_b_q <= win_b;
            if (a_req && b_req) begin
              last_b_q <= win_b;
            end
            we_q           <= win_b ? b_we        : a_we;
            mem_addr       <= win_b ? b_addr      : a_addr;
            mem_write_data <= win_b ? b_wdata     : a_wdata;
            mem_sign_mask  <= win_b ? b_sign_mask : a_sign_mask;
            mem_memwrite   <= win_b ? b_we        : a_we;
            mem_memread    <= win_b ? ~b_we       : ~a_we;
            busy           <= 1'b1;
            state_q        <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          mem_memwrite <= 1'b0;
          mem_memread  <= 1'b0;
          cnt_q        <= 8'd0;
          state_q      <= S_WAIT;
        end

        S_WAIT: begin
          cnt_q <= cnt_inc;
          // Stall still high here means the watchdog expired: report an error with zero data
          if (!mem_clk_stall || (cnt_inc == TIMEOUT_LIMIT)) begin
            if (sel_b_q) begin
              b_ack   <= 1'b1;
              b_rdata <= rdata_cap;
              b_err   <= mem_clk_stall;
            end else begin
              a_ack   <= 1'b1;
              a_rdata <= rdata_cap;
              a_err   <= mem_clk_stall;
            end
            state_q <= S_DONE;
          end
        end

        S_DONE: begin
          a_ack   <= 1'b0;
          a_rdata <= 32'd0;
          a_err   <= 1'b0;
          b_ack   <= 1'b0;
          b_rdata <= 32'd0;
          b_err   <= 1'b0;
          busy    <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
// Module  : tb_dmem_arbiter
// Brief   : Directed self-checking bench for dmem_arbiter with a small stalling
//           memory model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_req = 1'b0, a_we = 1'b0;
  logic [31:0] a_addr = '0, a_wdata = '0;
  logic [3:0]  a_sign_mask = '0;
  logic        b_req = 1'b0, b_we = 1'b0;
  logic [31:0] b_addr = '0, b_wdata = '0;
  logic [3:0]  b_sign_mask = '0;
  logic        a_ack, a_err, b_ack, b_err;
  logic [31:0] a_rdata, b_rdata;
  logic [31:0] mem_addr, mem_write_data;
  logic        mem_memwrite, mem_memread;
  logic [3:0]  mem_sign_mask;
  logic [31:0] mem_read_data = '0;
  logic        mem_clk_stall;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  dmem_arbiter #(.TIMEOUT_CYCLES(16), .A_FIRST(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_sign_mask(a_sign_mask), .a_ack(a_ack), .a_rdata(a_rdata), .a_err(a_err),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_sign_mask(b_sign_mask), .b_ack(b_ack), .b_rdata(b_rdata), .b_err(b_err),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_memwrite(mem_memwrite), .mem_memread(mem_memread),
    .mem_sign_mask(mem_sign_mask), .mem_read_data(mem_read_data),
    .mem_clk_stall(mem_clk_stall), .busy(busy)
  );

  always #5 clk = ~clk;

  // Memory model: a command raises stall for stall_len cycles; force_stall models a hung memory
  int stall_len   = 1;
  int stall_cnt   = 0;
  bit force_stall = 1'b0;
  always @(posedge clk) begin
    if (mem_memread || mem_memwrite) stall_cnt <= stall_len;
    else if (stall_cnt > 0)          stall_cnt <= stall_cnt - 1;
  end
  assign mem_clk_stall = force_stall || (stall_cnt != 0);

  // Event counters sampled just after each rising edge
  int rd_pulses = 0, wr_pulses = 0, a_acks = 0, b_acks = 0, both_ack = 0, both_cmd = 0;
  always @(posedge clk) begin
    #1;
    if (mem_memread)                 rd_pulses++;
    if (mem_memwrite)                wr_pulses++;
    if (a_ack)                       a_acks++;
    if (b_ack)                       b_acks++;
    if (a_ack && b_ack)              both_ack++;
    if (mem_memread && mem_memwrite) both_cmd++;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    a_req = 1'b0; b_req = 1'b0; a_we = 1'b0; b_we = 1'b0;
    force_stall = 1'b0; stall_len = 1;
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  // Waits for the chosen ack; edges = number of rising edges taken, -1 if it never came
  task automatic wait_ack(input bit side_b, output int edges);
    edges = -1;
    for (int i = 1; i <= 100; i++) begin
      step();
      if ((side_b ? b_ack : a_ack) === 1'b1) begin
        edges = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    step(); step();
    n_tests++;
    if ({busy, a_ack, b_ack, a_err, b_err, mem_memread, mem_memwrite} !== 7'd0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 0", {busy, a_ack, b_ack, a_err, b_err, mem_memread, mem_memwrite});
    end
    n_tests++;
    if ({mem_addr, mem_write_data, mem_sign_mask, a_rdata, b_rdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: addr %h wdata %h mask %h ardata %h brdata %h want all 0",
               mem_addr, mem_write_data, mem_sign_mask, a_rdata, b_rdata);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_read();
    int e, b0;
    do_reset();
    b0 = b_acks;
    stall_len = 2; mem_read_data = 32'hDEADBEEF;
    a_we = 1'b0; a_addr = 32'h1004; a_sign_mask = 4'b1111; a_req = 1'b1;
    step();
    n_tests++;
    if ({mem_memread, mem_memwrite, busy} !== 3'b101 || mem_addr !== 32'h1004) begin
      n_fail++;
      $display("FAIL read_issue: rd/wr/busy %b addr %h want 101 addr 00001004", {mem_memread, mem_memwrite, busy}, mem_addr);
    end
    step();
    n_tests++;
    if (mem_memread !== 1'b0) begin
      n_fail++;
      $display("FAIL read_pulse_width: memread %b want 0 after one cycle", mem_memread);
    end
    wait_ack(1'b0, e);
    n_tests++;
    if (e + 2 !== 5) begin
      n_fail++;
      $display("FAIL read_latency: got %0d edges want 5", e + 2);
    end
    n_tests++;
    if (a_rdata !== 32'hDEADBEEF || a_err !== 1'b0) begin
      n_fail++;
      $display("FAIL read_data: rdata %h err %b want deadbeef 0", a_rdata, a_err);
    end
    a_req = 1'b0;
    step();
    n_tests++;
    if (a_ack !== 1'b0 || busy !== 1'b0 || b_acks !== b0) begin
      n_fail++;
      $display("FAIL read_after: ack %b busy %b b_acks %0d want 0 0 %0d", a_ack, busy, b_acks, b0);
    end
  endtask

  task automatic test_round_robin();
    int side, k;
    do_reset();
    stall_len = 1; mem_read_data = 32'hCAFE0001;
    a_we = 1'b1; a_addr = 32'h1000; a_wdata = 32'h11; a_sign_mask = 4'b1111;
    b_we = 1'b0; b_addr = 32'h1008; b_sign_mask = 4'b1111;
    a_req = 1'b1; b_req = 1'b1;
    step();
    n_tests++;
    if (mem_memwrite !== 1'b1 || mem_addr !== 32'h1000 || mem_write_data !== 32'h11) begin
      n_fail++;
      $display("FAIL rr_first_grant: wr %b addr %h wdata %h want 1 00001000 00000011", mem_memwrite, mem_addr, mem_write_data);
    end
    for (k = 0; k < 6; k++) begin
      side = -1;
      for (int i = 0; i < 40; i++) begin
        step();
        if (a_ack === 1'b1) begin side = 0; break; end
        if (b_ack === 1'b1) begin side = 1; break; end
      end
      n_tests++;
      if (side !== k % 2) begin
        n_fail++;
        $display("FAIL rr_order[%0d]: granted side %0d want %0d (0=A 1=B)", k, side, k % 2);
      end
      n_tests++;
      if (side == 1 ? (b_rdata !== 32'hCAFE0001) : (a_rdata !== 32'h0)) begin
        n_fail++;
        $display("FAIL rr_rdata[%0d]: a_rdata %h b_rdata %h", k, a_rdata, b_rdata);
      end
    end
    a_req = 1'b0; b_req = 1'b0;
    step(); step();
    n_tests++;
    if (both_ack !== 0 || both_cmd !== 0) begin
      n_fail++;
      $display("FAIL rr_exclusive: both_ack %0d both_cmd %0d want 0 0", both_ack, both_cmd);
    end
  endtask

  task automatic test_timeout();
    int e, r0;
    do_reset();
    mem_read_data = 32'h12345678;
    a_we = 1'b0; a_addr = 32'h1010; a_req = 1'b1;
    step();
    force_stall = 1'b1;
    wait_ack(1'b0, e);
    n_tests++;
    if (e + 1 !== 18) begin
      n_fail++;
      $display("FAIL timeout_latency: got %0d edges want 18", e + 1);
    end
    n_tests++;
    if (a_err !== 1'b1 || a_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL timeout_flags: err %b rdata %h want 1 00000000", a_err, a_rdata);
    end
    a_req = 1'b0;
    b_we = 1'b0; b_addr = 32'h1014; b_req = 1'b1;
    r0 = rd_pulses;
    repeat (4) step();
    n_tests++;
    if (rd_pulses !== r0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_hold: rd_pulses %0d busy %b want %0d 0", rd_pulses, busy, r0);
    end
    force_stall = 1'b0;
    step();
    n_tests++;
    if (mem_memread !== 1'b1 || mem_addr !== 32'h1014) begin
      n_fail++;
      $display("FAIL timeout_reissue: rd %b addr %h want 1 00001014", mem_memread, mem_addr);
    end
    wait_ack(1'b1, e);
    n_tests++;
    if (e === -1 || b_err !== 1'b0 || b_rdata !== 32'h12345678) begin
      n_fail++;
      $display("FAIL timeout_next: edges %0d err %b rdata %h want ack 0 12345678", e, b_err, b_rdata);
    end
    b_req = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_access();
    int e, b0, r0;
    do_reset();
    mem_read_data = 32'h0BADF00D;
    b_we = 1'b0; b_addr = 32'h3000; b_sign_mask = 4'b0001; b_req = 1'b1;
    b0 = b_acks;
    step();
    force_stall = 1'b1;
    step(); step();
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_wait: busy %b want 1", busy);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({busy, a_ack, b_ack, mem_memread, mem_memwrite} !== 5'd0 || {mem_addr, mem_sign_mask, b_rdata} !== '0) begin
      n_fail++;
      $display("FAIL rst_async: ctrl %b addr %h mask %h rdata %h want all 0",
               {busy, a_ack, b_ack, mem_memread, mem_memwrite}, mem_addr, mem_sign_mask, b_rdata);
    end
    step(); step();
    rst_n = 1'b1;
    r0 = rd_pulses;
    step(); step();
    n_tests++;
    if (rd_pulses !== r0 || b_acks !== b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_no_issue: rd_pulses %0d b_acks %0d busy %b want %0d %0d 0", rd_pulses, b_acks, busy, r0, b0);
    end
    force_stall = 1'b0;
    step();
    n_tests++;
    if (mem_memread !== 1'b1 || mem_addr !== 32'h3000) begin
      n_fail++;
      $display("FAIL rst_reissue: rd %b addr %h want 1 00003000", mem_memread, mem_addr);
    end
    wait_ack(1'b1, e);
    b_req = 1'b0;
    n_tests++;
    if (e === -1 || b_acks !== b0 + 1 || b_rdata !== 32'h0BADF00D) begin
      n_fail++;
      $display("FAIL rst_single_ack: edges %0d b_acks %0d rdata %h want %0d 0badf00d", e, b_acks, b_rdata, b0 + 1);
    end
    step();
  endtask

  task automatic test_dropped_req();
    int e, b0, r0;
    do_reset();
    stall_len = 4; mem_read_data = 32'h55AA55AA;
    b0 = b_acks; r0 = rd_pulses;
    a_we = 1'b0; a_addr = 32'h1020; a_req = 1'b1;
    step();
    b_we = 1'b0; b_addr = 32'h1024; b_req = 1'b1;
    step(); step();
    b_req = 1'b0;
    wait_ack(1'b0, e);
    n_tests++;
    if (e + 3 !== 7 || a_rdata !== 32'h55AA55AA) begin
      n_fail++;
      $display("FAIL drop_a_ack: edges %0d rdata %h want 7 55aa55aa", e + 3, a_rdata);
    end
    a_req = 1'b0;
    step();
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_busy: busy %b want 0", busy);
    end
    repeat (8) step();
    n_tests++;
    if (b_acks !== b0 || rd_pulses !== r0 + 1) begin
      n_fail++;
      $display("FAIL drop_no_b: b_acks %0d rd_pulses %0d want %0d %0d", b_acks, rd_pulses, b0, r0 + 1);
    end
  endtask

  task automatic test_write_mask();
    int e;
    do_reset();
    stall_len = 1; mem_read_data = 32'hFFFFFFFF;
    a_we = 1'b1; a_addr = 32'h2000; a_wdata = 32'hA5A51234; a_sign_mask = 4'b0011; a_req = 1'b1;
    step();
    n_tests++;
    if ({mem_memwrite, mem_memread} !== 2'b10 || mem_sign_mask !== 4'b0011 ||
        mem_write_data !== 32'hA5A51234 || mem_addr !== 32'h2000) begin
      n_fail++;
      $display("FAIL write_issue: wr/rd %b mask %b wdata %h addr %h want 10 0011 a5a51234 00002000",
               {mem_memwrite, mem_memread}, mem_sign_mask, mem_write_data, mem_addr);
    end
    wait_ack(1'b0, e);
    n_tests++;
    if (e + 1 !== 4 || a_rdata !== 32'h0 || a_err !== 1'b0) begin
      n_fail++;
      $display("FAIL write_ack: edges %0d rdata %h err %b want 4 00000000 0", e + 1, a_rdata, a_err);
    end
    a_req = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_timeout();
    test_reset_mid_access();
    test_dropped_req();
    test_write_mask();
    n_tests++;
    if (both_cmd !== 0 || both_ack !== 0) begin
      n_fail++;
      $display("FAIL global_exclusive: both_cmd %0d both_ack %0d want 0 0", both_cmd, both_ack);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
